// File: rtl/cpu_flags_pkg.sv
// Shared flag definitions for the ALU flag unit and the branch logic.
// Bit positions of flags_q and the leading-zero count width helper.
package cpu_flags_pkg;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } flags_t;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  function automatic int lzc_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/lzc_tree.sv
// Combinational leading-zero counter built as a log2 tree of 2-bit priority encoders.
// Zero latency; no flow control. all_zero doubles as the zero-result detector.
module lzc_tree
  import cpu_flags_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int LZCW = lzc_width(WIDTH)
) (
  input  logic [WIDTH-1:0] data,
  output logic [LZCW-1:0]  lzc,
  output logic             all_zero
);

  localparam int L = $clog2(WIDTH);
  localparam int P = 1 << L;

  logic [P-1:0] padded;
  logic         nz  [P];
  logic [L-1:0] cnt [P];

  always_comb begin
    // Pad below the LSB with ones so the padding never adds to the count.
    padded = '1;
    padded[P-1 -: WIDTH] = data;
    for (int i = 0; i < P; i++) begin
      nz[i]  = padded[i];
      cnt[i] = '0;
    end
    // Each level merges sibling pairs in place; node j only reads nodes >= j.
    for (int lvl = 0; lvl < L; lvl++) begin
      for (int j = 0; j < (P >> (lvl + 1)); j++) begin
        cnt[j] = nz[2*j+1] ? cnt[2*j+1] : (cnt[2*j] | (L'(1) << lvl));
        nz[j]  = nz[2*j+1] | nz[2*j];
      end
    end
    lzc      = nz[0] ? LZCW'(cnt[0]) : LZCW'(WIDTH);
    all_zero = (lzc == LZCW'(WIDTH));
  end

endmodule

// File: rtl/alu_flag_unit.sv
// Pipelined zero/negative/carry/overflow/lzc generator with committed flags and sticky zero.
// Latency LATENCY cycles; valid/ready pipeline, in_ready falls only when every stage is full and stalled.
module alu_flag_unit
  import cpu_flags_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 1,
  parameter int LZC_EN  = 1,
  localparam int LZCW   = lzc_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] result,
  input  logic             carry_in,
  input  logic             ovf_in,
  input  logic             flags_we,
  input  logic             flush,
  input  logic             sticky_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow,
  output logic [LZCW-1:0]  lzc,
  output logic [3:0]       flags_q,
  output logic             sticky_zero
);

  localparam int LAST = LATENCY - 1;

  typedef struct packed {
    flags_t          flg;
    logic            we;
    logic [LZCW-1:0] lzc;
  } ent_t;

  ent_t [LATENCY-1:0] ent_q;
  ent_t [LATENCY-1:0] ent_d;
  logic [LATENCY-1:0] vld_q;
  logic [LATENCY-1:0] leave;
  logic [LATENCY-1:0] load;
  logic [LATENCY:0]   adv;
  logic [LZCW-1:0]    lzc_c;
  logic               zero_c;
  flags_t             flags_r;
  logic               hs;

  generate
    if (LZC_EN != 0) begin : g_lzc
      lzc_tree #(.WIDTH(WIDTH)) u_lzc (
        .data     (result),
        .lzc      (lzc_c),
        .all_zero (zero_c)
      );
    end else begin : g_nolzc
      assign lzc_c  = '0;
      assign zero_c = ~|result;
    end
  endgenerate

  // A stage can take new data when it is empty or its occupant is leaving.
  always_comb begin
    adv[LATENCY] = out_ready;
    for (int i = LATENCY - 1; i >= 0; i--) begin
      leave[i] = vld_q[i] & adv[i+1];
      adv[i]   = ~vld_q[i] | leave[i];
    end
    load[0]      = in_valid & adv[0];
    ent_d[0].flg = '{z: zero_c, n: result[WIDTH-1], c: carry_in, v: ovf_in};
    ent_d[0].we  = flags_we;
    ent_d[0].lzc = lzc_c;
    for (int i = 1; i < LATENCY; i++) begin
      load[i]  = leave[i-1];
      ent_d[i] = ent_q[i-1];
    end
  end

  assign in_ready = adv[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      ent_q <= '0;
    end else begin
      for (int i = 0; i < LATENCY; i++) begin
        if (flush)         vld_q[i] <= 1'b0;
        else if (load[i])  vld_q[i] <= 1'b1;
        else if (leave[i]) vld_q[i] <= 1'b0;
        if (load[i]) ent_q[i] <= ent_d[i];
      end
    end
  end

  assign hs = vld_q[LAST] & out_ready;

  // Setting sticky_zero takes priority over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_r     <= '0;
      sticky_zero <= 1'b0;
    end else begin
      if (hs && ent_q[LAST].we) flags_r <= ent_q[LAST].flg;
      if (hs && ent_q[LAST].we && ent_q[LAST].flg.z) sticky_zero <= 1'b1;
      else if (sticky_clr)                             sticky_zero <= 1'b0;
    end
  end

  assign out_valid = vld_q[LAST];
  assign zero      = ent_q[LAST].flg.z;
  assign negative  = ent_q[LAST].flg.n;
  assign carry     = ent_q[LAST].flg.c;
  assign overflow  = ent_q[LAST].flg.v;
  assign lzc       = ent_q[LAST].lzc;
  assign flags_q   = flags_r;

endmodule

// File: tb/tb_alu_flag_unit.sv
// Directed bench for alu_flag_unit at WIDTH=32, LATENCY=2.
module tb_alu_flag_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] result;
  logic        carry_in, ovf_in, flags_we, flush, sticky_clr;
  logic        out_valid, out_ready;
  logic        zero, negative, carry, overflow;
  logic [5:0]  lzc;
  logic [3:0]  flags_q;
  logic        sticky_zero;

  alu_flag_unit #(.WIDTH(32), .LATENCY(2), .LZC_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .result(result), .carry_in(carry_in), .ovf_in(ovf_in), .flags_we(flags_we),
    .flush(flush), .sticky_clr(sticky_clr), .out_valid(out_valid), .out_ready(out_ready),
    .zero(zero), .negative(negative), .carry(carry), .overflow(overflow),
    .lzc(lzc), .flags_q(flags_q), .sticky_zero(sticky_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        c, v, we;
    logic        z, n;
    logic [5:0]  lzc;
  } vec_t;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [3:0] exp_flags = 4'b0000;
  logic       exp_sticky = 1'b0;
  vec_t       tbl [8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic v, input logic [31:0] r, input logic c, input logic o, input logic we);
    in_valid = v; result = r; carry_in = c; ovf_in = o; flags_we = we;
  endtask

  // One isolated transaction: accept, check latency and outputs, then the commit.
  task automatic run_vec(input vec_t t, input logic sclr, input string tag);
    @(negedge clk);
    set_in(1'b1, t.res, t.c, t.v, t.we);
    out_ready = 1'b1;
    #1 chk({tag, ".in_ready"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, ".early_valid"}, out_valid, 0);
    @(negedge clk);
    chk({tag, ".out_valid"}, out_valid, 1);
    chk({tag, ".zero"}, zero, t.z);
    chk({tag, ".negative"}, negative, t.n);
    chk({tag, ".carry"}, carry, t.c);
    chk({tag, ".overflow"}, overflow, t.v);
    chk({tag, ".lzc"}, lzc, t.lzc);
    sticky_clr = sclr;
    if (t.we) exp_flags = {t.z, t.n, t.c, t.v};
    if (t.we && t.z) exp_sticky = 1'b1;
    else if (sclr)   exp_sticky = 1'b0;
    @(negedge clk);
    sticky_clr = 1'b0;
    chk({tag, ".flags_q"}, flags_q, exp_flags);
    chk({tag, ".sticky"}, sticky_zero, exp_sticky);
    chk({tag, ".drained"}, out_valid, 0);
  endtask

  initial begin
    logic [31:0] sres [3];
    logic [5:0]  slzc [3];
    logic        sneg [3];
    logic        rdy_exp [5];
    vec_t        zv;

    tbl[0] = '{res: 32'h0000_0000, c: 0, v: 0, we: 1, z: 1, n: 0, lzc: 6'd32};
    tbl[1] = '{res: 32'h8000_0000, c: 1, v: 0, we: 1, z: 0, n: 1, lzc: 6'd0};
    tbl[2] = '{res: 32'h0001_0000, c: 0, v: 1, we: 1, z: 0, n: 0, lzc: 6'd15};
    tbl[3] = '{res: 32'h0000_0001, c: 1, v: 1, we: 0, z: 0, n: 0, lzc: 6'd31};
    tbl[4] = '{res: 32'h0000_0000, c: 0, v: 0, we: 0, z: 1, n: 0, lzc: 6'd32};
    tbl[5] = '{res: 32'h7FFF_FFFF, c: 0, v: 1, we: 1, z: 0, n: 0, lzc: 6'd1};
    tbl[6] = '{res: 32'h00FF_0000, c: 1, v: 0, we: 1, z: 0, n: 0, lzc: 6'd8};
    tbl[7] = '{res: 32'hFFFF_FFFF, c: 0, v: 0, we: 1, z: 0, n: 1, lzc: 6'd0};

    rst_n = 1'b0; out_ready = 1'b1; flush = 1'b0; sticky_clr = 1'b0;
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.flags_q", flags_q, 0);
    chk("rst.sticky", sticky_zero, 0);
    chk("rst.zero", zero, 0);
    chk("rst.lzc", lzc, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst.in_ready", in_ready, 1);

    // Table of isolated transactions
    for (int i = 0; i < 8; i++) run_vec(tbl[i], 1'b0, $sformatf("vec%0d", i));

    // Back-to-back stream, no bubbles
    sres[0] = 32'h8000_0000; slzc[0] = 6'd0;  sneg[0] = 1'b1;
    sres[1] = 32'h0001_0000; slzc[1] = 6'd15; sneg[1] = 1'b0;
    sres[2] = 32'h0000_0001; slzc[2] = 6'd31; sneg[2] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        chk($sformatf("stream%0d.valid", k - 2), out_valid, 1);
        chk($sformatf("stream%0d.lzc", k - 2), lzc, slzc[k-2]);
        chk($sformatf("stream%0d.neg", k - 2), negative, sneg[k-2]);
      end
      if (k < 3) begin
        set_in(1'b1, sres[k], 1'b0, 1'b0, 1'b0);
        #1 chk($sformatf("stream%0d.in_ready", k), in_ready, 1);
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    chk("stream.drained", out_valid, 0);

    // Backpressure stall
    rdy_exp[0] = 1; rdy_exp[1] = 1; rdy_exp[2] = 0; rdy_exp[3] = 0; rdy_exp[4] = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      out_ready = 1'b0;
      if (k == 0)      set_in(1'b1, 32'h0000_0100, 1'b1, 1'b0, 1'b1);
      else if (k == 1) set_in(1'b1, 32'h0002_0000, 1'b0, 1'b1, 1'b1);
      else             set_in(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1);
      #1 chk($sformatf("stall%0d.in_ready", k), in_ready, rdy_exp[k]);
      chk($sformatf("stall%0d.flags_q", k), flags_q, exp_flags);
      if (k >= 2) begin
        chk($sformatf("stall%0d.valid", k), out_valid, 1);
        chk($sformatf("stall%0d.lzc", k), lzc, 23);
      end
    end
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b0;
    chk("stall.rel0.valid", out_valid, 1);
    chk("stall.rel0.lzc", lzc, 23);
    @(negedge clk);
    chk("stall.rel0.flags_q", flags_q, 4'b0010);
    chk("stall.rel1.valid", out_valid, 1);
    chk("stall.rel1.lzc", lzc, 14);
    @(negedge clk);
    chk("stall.rel1.flags_q", flags_q, 4'b0001);
    chk("stall.drained", out_valid, 0);
    exp_flags = 4'b0001;

    // Sticky clear alone, zero without flags_we, then set-wins-over-clear
    @(negedge clk);
    sticky_clr = 1'b1;
    @(negedge clk);
    sticky_clr = 1'b0;
    chk("sticky.clr_alone", sticky_zero, 0);
    exp_sticky = 1'b0;
    zv = '{res: 32'h0, c: 0, v: 0, we: 0, z: 1, n: 0, lzc: 6'd32};
    run_vec(zv, 1'b0, "zero_nowe");
    zv.we = 1'b1;
    run_vec(zv, 1'b1, "set_wins");

    // Flush with two entries in flight and in_valid high
    @(negedge clk);
    out_ready = 1'b0;
    set_in(1'b1, 32'h0000_0100, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    set_in(1'b1, 32'h0002_0000, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    chk("flush.pre_valid", out_valid, 1);
    set_in(1'b1, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush.valid_gone", out_valid, 0);
    chk("flush.flags_q", flags_q, exp_flags);
    out_ready = 1'b1;
    set_in(1'b1, 32'h8000_0001, 1'b1, 1'b0, 1'b1);
    #1 chk("flush.in_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("flush.no_leak", out_valid, 0);
    @(negedge clk);
    chk("flush.next.valid", out_valid, 1);
    chk("flush.next.lzc", lzc, 0);
    chk("flush.next.neg", negative, 1);
    @(negedge clk);
    chk("flush.next.flags_q", flags_q, 4'b0110);
    chk("flush.drained", out_valid, 0);
    chk("flush.sticky", sticky_zero, 1);

    // Asynchronous reset mid-stream
    @(negedge clk);
    out_ready = 1'b0;
    set_in(1'b1, 32'h0000_0100, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    set_in(1'b1, 32'h0000_0200, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("arst.pre_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.out_valid", out_valid, 0);
    chk("arst.flags_q", flags_q, 0);
    chk("arst.sticky", sticky_zero, 0);
    chk("arst.lzc", lzc, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst.in_ready", in_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
